// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised register file with bypass, zero entry and clear sweep
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wAddr,
    input  logic [DATA_WIDTH-1:0]        wData,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rAddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rData,
    output logic [NUM_RD-1:0]            rValid,
    output logic [(2**ADDR_WIDTH)-1:0]   to_reg,
    input  logic                         clr_req,
    output logic                         busy,
    output logic                         clr_done,
    output logic                         wr_err
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic                    last;
    logic                    acc;
    logic                    wr_ok;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (clr_req) state_nxt = S_CLEAR;
            S_CLEAR: if (ptr == LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_CLEAR);
        last = (state == S_CLEAR) && (ptr == LAST);
    end

    assign acc   = we & ~busy;
    // Writes to a hardwired-zero entry are accepted but never land anywhere.
    assign wr_ok = acc && !((ZERO_REG != 0) && (wAddr == '0));

    always_comb begin
        to_reg = '0;
        if (wr_ok) to_reg[wAddr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            clr_done <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            clr_done <= last;
            wr_err   <= we & busy;
            if (busy && !last) ptr <= ptr + 1'b1;
            else               ptr <= '0;
        end
    end

    // Sweep and write never collide: acceptance is blocked while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid <= '0;
        end else if (busy) begin
            mem[ptr]   <= '0;
            valid[ptr] <= 1'b0;
        end else if (wr_ok) begin
            mem[wAddr]   <= wData;
            valid[wAddr] <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  zero_hit;
        logic                  byp_hit;
        assign ra       = rAddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);
        assign byp_hit  = (BYPASS != 0) && acc && (wAddr == ra);
        assign rData[gi*DATA_WIDTH +: DATA_WIDTH] = zero_hit ? '0 : (byp_hit ? wData : mem[ra]);
        assign rValid[gi] = zero_hit | byp_hit | valid[ra];
    end
endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - self-checking bench for param_register_file
module tb_param_register_file;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic        clr_req = 1'b0;
    logic [2:0]  wAddr = '0;
    logic [31:0] wData = '0;
    logic [5:0]  rAddr = '0;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rvalid_a, rvalid_b;
    logic [7:0]  to_reg_a, to_reg_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_data [2][8];
    bit          m_valid [2][8];
    bit          m_busy, m_done, m_err;
    int          m_ptr;

    always #5 clk = ~clk;

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData), .rAddr(rAddr),
        .rData(rdata_a), .rValid(rvalid_a), .to_reg(to_reg_a), .clr_req(clr_req),
        .busy(busy_a), .clr_done(done_a), .wr_err(err_a));

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData), .rAddr(rAddr),
        .rData(rdata_b), .rValid(rvalid_b), .to_reg(to_reg_b), .clr_req(clr_req),
        .busy(busy_b), .clr_done(done_b), .wr_err(err_b));

    function automatic void model_reset();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 8; a++) begin
                m_data[c][a]  = '0;
                m_valid[c][a] = 1'b0;
            end
        m_busy = 0; m_done = 0; m_err = 0; m_ptr = 0;
    endfunction

    // Instance 0: bypass, no zero entry. Instance 1: no bypass, zero entry.
    function automatic void model_edge();
        bit acc, nd, ne;
        if (reset) begin
            model_reset();
            return;
        end
        acc = we && !m_busy;
        nd  = 0;
        ne  = we && m_busy;
        if (m_busy) begin
            for (int c = 0; c < 2; c++) begin
                m_data[c][m_ptr]  = '0;
                m_valid[c][m_ptr] = 1'b0;
            end
            if (m_ptr == 7) begin m_busy = 0; nd = 1; m_ptr = 0; end
            else m_ptr++;
        end else if (clr_req) begin
            m_busy = 1; m_ptr = 0;
        end
        if (acc)
            for (int c = 0; c < 2; c++)
                if (!(c == 1 && wAddr == 0)) begin
                    m_data[c][wAddr]  = wData;
                    m_valid[c][wAddr] = 1'b1;
                end
        m_done = nd;
        m_err  = ne;
    endfunction

    function automatic logic [31:0] exp_rd(int c, int p);
        int a = int'(rAddr[p*3 +: 3]);
        if (c == 1 && a == 0) return '0;
        if (c == 0 && we && !m_busy && int'(wAddr) == a) return wData;
        return m_data[c][a];
    endfunction

    function automatic logic exp_rv(int c, int p);
        int a = int'(rAddr[p*3 +: 3]);
        if (c == 1 && a == 0) return 1'b1;
        if (c == 0 && we && !m_busy && int'(wAddr) == a) return 1'b1;
        return m_valid[c][a];
    endfunction

    function automatic logic [7:0] exp_to(int c);
        if (we && !m_busy && !(c == 1 && wAddr == 0)) return 8'(1 << wAddr);
        return 8'h00;
    endfunction

    function automatic logic [31:0] act_rd(int c, int p);
        return (c == 0) ? rdata_a[p*32 +: 32] : rdata_b[p*32 +: 32];
    endfunction

    function automatic logic act_rv(int c, int p);
        return (c == 0) ? rvalid_a[p] : rvalid_b[p];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic fill_all();
        we = 1'b1;
        for (int a = 0; a < 8; a++) begin
            wAddr = 3'(a);
            wData = $urandom;
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b0;
        we = 1'b1; wAddr = 3'd2; wData = $urandom; rAddr = {3'd2, 3'd2};
        tick();
        we = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (act_rd(c, p) !== 32'h0) begin
                    errors++; $display("FAIL reset_rdata c%0d p%0d: got %h expected 0", c, p, act_rd(c, p));
                end
                checks++;
                if (act_rv(c, p) !== (c == 1 ? 1'b0 : 1'b0)) begin
                    errors++; $display("FAIL reset_rvalid c%0d p%0d: got %b expected 0", c, p, act_rv(c, p));
                end
            end
        end
        checks++;
        if ({busy_a, busy_b, done_a, err_a, to_reg_a, to_reg_b} !== '0) begin
            errors++; $display("FAIL reset_ctrl: got busy=%b done=%b err=%b to_reg=%h/%h expected all 0",
                               busy_a, done_a, err_a, to_reg_a, to_reg_b);
        end
        tick();
        reset = 1'b0;
        we = 1'b1; wAddr = 3'd5; wData = 32'hDEADBEEF; rAddr = {3'd5, 3'd5};
        tick();
        we = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (act_rd(c, 0) !== 32'hDEADBEEF || act_rv(c, 0) !== 1'b1) begin
                errors++; $display("FAIL first_write c%0d: got %h/%b expected deadbeef/1", c, act_rd(c, 0), act_rv(c, 0));
            end
        end
    endtask

    task automatic test_decode();
        for (int a = 0; a < 8; a++) begin
            we = 1'b1; wAddr = 3'(a); wData = $urandom;
            #1;
            checks++;
            if (to_reg_a !== 8'(1 << a)) begin
                errors++; $display("FAIL decode_a addr%0d: got %h expected %h", a, to_reg_a, 8'(1 << a));
            end
            checks++;
            if (to_reg_b !== (a == 0 ? 8'h00 : 8'(1 << a))) begin
                errors++; $display("FAIL decode_b addr%0d: got %h expected %h", a, to_reg_b, (a == 0 ? 8'h00 : 8'(1 << a)));
            end
            tick();
        end
        we = 1'b0;
        #1;
        checks++;
        if (to_reg_a !== 8'h00 || to_reg_b !== 8'h00) begin
            errors++; $display("FAIL decode_idle: got %h/%h expected 00", to_reg_a, to_reg_b);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; wAddr = 3'd3; wData = 32'hAAAA0003;
        tick();
        wData = 32'h12345678; rAddr = {3'd1, 3'd3};
        #1;
        checks++;
        if (rdata_a[31:0] !== 32'h12345678) begin
            errors++; $display("FAIL bypass_on: got %h expected 12345678", rdata_a[31:0]);
        end
        checks++;
        if (rdata_b[31:0] !== 32'hAAAA0003) begin
            errors++; $display("FAIL bypass_off_old: got %h expected aaaa0003", rdata_b[31:0]);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rdata_b[31:0] !== 32'h12345678) begin
            errors++; $display("FAIL bypass_off_new: got %h expected 12345678", rdata_b[31:0]);
        end
    endtask

    task automatic test_zero();
        we = 1'b1; wAddr = 3'd0; wData = 32'hFFFFFFFF; rAddr = 6'd0;
        #1;
        checks++;
        if (to_reg_b !== 8'h00 || to_reg_a !== 8'h01) begin
            errors++; $display("FAIL zero_to_reg: got %h/%h expected 01/00", to_reg_a, to_reg_b);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (rdata_b !== 64'h0 || rvalid_b !== 2'b11) begin
            errors++; $display("FAIL zero_read: got %h/%b expected 0/11", rdata_b, rvalid_b);
        end
        checks++;
        if (rdata_a[31:0] !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL zero_other: got %h expected ffffffff", rdata_a[31:0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            wAddr = 3'($urandom);
            wData = $urandom;
            rAddr = 6'($urandom);
            clr_req = ($urandom_range(0, 39) == 0);
            #1;
            for (int c = 0; c < 2; c++) begin
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (act_rd(c, p) !== exp_rd(c, p) || act_rv(c, p) !== exp_rv(c, p)) begin
                        errors++; $display("FAIL rand_read n%0d c%0d p%0d: got %h/%b expected %h/%b",
                                           n, c, p, act_rd(c, p), act_rv(c, p), exp_rd(c, p), exp_rv(c, p));
                    end
                end
            end
            checks++;
            if (to_reg_a !== exp_to(0) || to_reg_b !== exp_to(1)) begin
                errors++; $display("FAIL rand_to_reg n%0d: got %h/%h expected %h/%h", n, to_reg_a, to_reg_b, exp_to(0), exp_to(1));
            end
            checks++;
            if (busy_a !== m_busy || done_a !== m_done || err_a !== m_err || busy_b !== m_busy) begin
                errors++; $display("FAIL rand_ctrl n%0d: got busy=%b done=%b err=%b expected %b/%b/%b",
                                   n, busy_a, done_a, err_a, m_busy, m_done, m_err);
            end
            tick();
        end
        we = 1'b0; clr_req = 1'b0;
        for (int n = 0; n < 10 && m_busy; n++) tick();
    endtask

    task automatic test_clear();
        int busy_cycles = 0;
        int done_cnt = 0;
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 11; k++) begin
            rAddr = {(k >= 1 ? 3'(k - 1) : 3'd0), 3'(k)};
            we = (k == 2); wAddr = 3'd6; wData = 32'h0BADF00D;
            #1;
            if (busy_a) busy_cycles++;
            if (done_a) done_cnt++;
            checks++;
            if (busy_a !== (k < 8)) begin
                errors++; $display("FAIL clr_busy k%0d: got %b expected %b", k, busy_a, (k < 8));
            end
            checks++;
            if (done_a !== (k == 8) || err_a !== (k == 3)) begin
                errors++; $display("FAIL clr_pulses k%0d: got done=%b err=%b expected %b/%b", k, done_a, err_a, (k == 8), (k == 3));
            end
            if (k < 8) begin
                checks++;
                if (rvalid_a[0] !== 1'b1 || (k >= 1 && rvalid_a[1] !== 1'b0)) begin
                    errors++; $display("FAIL clr_order k%0d: got %b expected %b", k, rvalid_a, (k >= 1) ? 2'b01 : 2'b11);
                end
            end
            if (k == 2) begin
                checks++;
                if (to_reg_a !== 8'h00) begin
                    errors++; $display("FAIL clr_drop_strobe: got %h expected 00", to_reg_a);
                end
            end
            tick();
        end
        we = 1'b0;
        checks++;
        if (busy_cycles != 8 || done_cnt != 1) begin
            errors++; $display("FAIL clr_counts: got busy=%0d done=%0d expected 8/1", busy_cycles, done_cnt);
        end
        for (int a = 0; a < 8; a++) begin
            rAddr = {3'(a), 3'(a)};
            #1;
            checks++;
            if (rvalid_a !== 2'b00 || rvalid_b !== (a == 0 ? 2'b11 : 2'b00) || rdata_a !== 64'h0) begin
                errors++; $display("FAIL clr_after addr%0d: got %b/%b %h expected 00/%b 0", a, rvalid_a, rvalid_b, rdata_a, (a == 0 ? 2'b11 : 2'b00));
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int busy_cycles = 0;
        int done_cnt = 0;
        tick();
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL mid_reset_busy: got %b/%b expected 0", busy_a, busy_b);
        end
        for (int a = 0; a < 8; a++) begin
            rAddr = {3'(a), 3'(a)};
            #1;
            checks++;
            if (rdata_a !== 64'h0 || rvalid_a !== 2'b00) begin
                errors++; $display("FAIL mid_reset_entry addr%0d: got %h/%b expected 0/00", a, rdata_a, rvalid_a);
            end
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (done_a || done_b) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt != 0) begin
            errors++; $display("FAIL mid_reset_no_done: got %0d pulses expected 0", done_cnt);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (busy_a) busy_cycles++;
            if (done_a) done_cnt++;
            tick();
        end
        checks++;
        if (busy_cycles != 8 || done_cnt != 1) begin
            errors++; $display("FAIL resweep_counts: got busy=%0d done=%0d expected 8/1", busy_cycles, done_cnt);
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_decode();
        test_bypass();
        test_zero();
        test_random();
        test_clear();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
